// File: rtl/feed_pkg.sv
// Shared types and helpers for the feed arbiter slice.
package feed_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StGrant,
        StDrop
    } state_e;

    // Width of a source/beat index; never below one bit.
    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above start, wrapping.
module rr_pick
    import feed_pkg::*;
#(
    parameter int unsigned N_SRC = 4,
    parameter int unsigned ID_W  = id_width(N_SRC)
) (
    input  logic [N_SRC-1:0] req,
    input  logic [ID_W-1:0]  start,
    output logic [ID_W-1:0]  idx,
    output logic             found
);

    always_comb begin
        int unsigned cand;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int unsigned k = 0; k < N_SRC; k++) begin
            cand = (32'(start) + k) % N_SRC;
            if (!found && req[ID_W'(cand)]) begin
                idx   = ID_W'(cand);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/feed_arbiter.sv
// Packet-locked round-robin merge of N_SRC AXIS feeds, with truncation of over-long packets.
module feed_arbiter
    import feed_pkg::*;
#(
    parameter int unsigned WIDTH     = 64,
    parameter int unsigned N_SRC     = 4,
    parameter int unsigned MAX_BEATS = 256
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [N_SRC-1:0][WIDTH-1:0]      s_tdata,
    input  logic [N_SRC-1:0][WIDTH/8-1:0]    s_byteEnable,
    input  logic [N_SRC-1:0]                 s_tvalid,
    input  logic [N_SRC-1:0]                 s_tlast,
    output logic [N_SRC-1:0]                 s_tready,
    input  logic [N_SRC-1:0]                 src_enable,
    output logic [WIDTH-1:0]                 master_tdata,
    output logic [WIDTH/8-1:0]               master_byteEnable,
    output logic                             master_tvalid,
    output logic                             master_tlast,
    input  logic                             master_tready,
    output logic [id_width(N_SRC)-1:0]       master_tuser,
    output logic [15:0]                      trunc_count
);

    localparam int unsigned ID_W  = id_width(N_SRC);
    localparam int unsigned CNT_W = id_width(MAX_BEATS);

    state_e             state_q, state_d;
    logic [ID_W-1:0]    gnt_q, gnt_d;
    logic [ID_W-1:0]    rr_q, rr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [15:0]        trunc_q, trunc_d;

    logic [ID_W-1:0]    pick_idx;
    logic               pick_found;
    logic [ID_W-1:0]    gnt_next;
    logic               sel_valid;
    logic               sel_last;
    logic               at_limit;

    rr_pick #(
        .N_SRC (N_SRC),
        .ID_W  (ID_W)
    ) u_pick (
        .req   (s_tvalid & src_enable),
        .start (rr_q),
        .idx   (pick_idx),
        .found (pick_found)
    );

    assign gnt_next  = (gnt_q == ID_W'(N_SRC - 1)) ? '0 : gnt_q + 1'b1;
    assign sel_valid = s_tvalid[gnt_q];
    assign sel_last  = s_tlast[gnt_q];
    assign at_limit  = (cnt_q == CNT_W'(MAX_BEATS - 1));

    always_comb begin
        state_d           = state_q;
        gnt_d             = gnt_q;
        rr_d              = rr_q;
        cnt_d             = cnt_q;
        trunc_d           = trunc_q;
        s_tready          = '0;
        master_tvalid     = 1'b0;
        master_tlast      = 1'b0;
        master_tdata      = '0;
        master_byteEnable = '0;
        master_tuser      = '0;

        unique case (state_q)
            StIdle: begin
                if (pick_found) begin
                    gnt_d   = pick_idx;
                    state_d = StGrant;
                end
            end
            StGrant: begin
                master_tvalid     = sel_valid;
                master_tdata      = s_tdata[gnt_q];
                master_byteEnable = s_byteEnable[gnt_q];
                // The last allowed beat is presented as end-of-packet even if the source disagrees.
                master_tlast      = sel_last | at_limit;
                master_tuser      = gnt_q;
                s_tready[gnt_q]   = master_tready;
                if (sel_valid && master_tready) begin
                    if (sel_last) begin
                        rr_d    = gnt_next;
                        cnt_d   = '0;
                        state_d = StIdle;
                    end else if (at_limit) begin
                        cnt_d   = '0;
                        state_d = StDrop;
                        if (trunc_q != 16'hFFFF) begin
                            trunc_d = trunc_q + 16'd1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StDrop: begin
                s_tready[gnt_q] = 1'b1;
                if (sel_valid && sel_last) begin
                    rr_d    = gnt_next;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            gnt_q   <= '0;
            rr_q    <= '0;
            cnt_q   <= '0;
            trunc_q <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
            trunc_q <= trunc_d;
        end
    end

    assign trunc_count = trunc_q;

endmodule

// File: tb/tb_feed_arbiter.sv
// Directed bench for feed_arbiter: packet-level reference model plus literal spot checks.
module tb_feed_arbiter;

    localparam int WIDTH = 64;
    localparam int NS    = 4;
    localparam int MAXB  = 256;

    logic                      clk;
    logic                      rst;
    logic [NS-1:0][WIDTH-1:0]  s_tdata;
    logic [NS-1:0][7:0]        s_be;
    logic [NS-1:0]             s_tvalid;
    logic [NS-1:0]             s_tlast;
    logic [NS-1:0]             s_tready;
    logic [NS-1:0]             src_enable;
    logic [WIDTH-1:0]          master_tdata;
    logic [7:0]                master_be;
    logic                      master_tvalid;
    logic                      master_tlast;
    logic                      master_tready;
    logic [1:0]                master_tuser;
    logic [15:0]               trunc_count;

    feed_arbiter #(
        .WIDTH     (WIDTH),
        .N_SRC     (NS),
        .MAX_BEATS (MAXB)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .s_tdata           (s_tdata),
        .s_byteEnable      (s_be),
        .s_tvalid          (s_tvalid),
        .s_tlast           (s_tlast),
        .s_tready          (s_tready),
        .src_enable        (src_enable),
        .master_tdata      (master_tdata),
        .master_byteEnable (master_be),
        .master_tvalid     (master_tvalid),
        .master_tlast      (master_tlast),
        .master_tready     (master_tready),
        .master_tuser      (master_tuser),
        .trunc_count       (trunc_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Source models: npkt packets of plen beats each; data encodes source, packet, beat.
    int npkt [NS];
    int plen [NS];
    int seq  [NS];
    int pktno[NS];

    always_comb begin
        for (int i = 0; i < NS; i++) begin
            s_tvalid[i] = (npkt[i] > 0);
            s_tlast[i]  = (npkt[i] > 0) && (seq[i] == plen[i] - 1);
            s_tdata[i]  = {8'(i), 24'(pktno[i]), 32'(seq[i])};
            s_be[i]     = {4'(seq[i]), 4'(i)};
        end
    end

    // Reference model: who owns the output, whether we are discarding, and the counters.
    int m_owner;
    bit m_drop;
    int m_rr;
    int m_cnt;
    int m_trunc;

    always @(posedge clk or negedge rst) begin : model_upd
        int  c;
        bit  hit;
        if (!rst) begin
            m_owner <= -1;
            m_drop  <= 1'b0;
            m_rr    <= 0;
            m_cnt   <= 0;
            m_trunc <= 0;
        end else if (m_owner < 0) begin
            hit = 1'b0;
            for (int k = 0; k < NS; k++) begin
                c = (m_rr + k) % NS;
                if (!hit && s_tvalid[c] && src_enable[c]) begin
                    hit = 1'b1;
                    m_owner <= c;
                end
            end
        end else if (!m_drop) begin
            if (s_tvalid[m_owner] && master_tready) begin
                if (s_tlast[m_owner]) begin
                    m_rr    <= (m_owner + 1) % NS;
                    m_owner <= -1;
                    m_cnt   <= 0;
                end else if (m_cnt == MAXB - 1) begin
                    m_drop  <= 1'b1;
                    m_cnt   <= 0;
                    m_trunc <= (m_trunc < 65535) ? m_trunc + 1 : m_trunc;
                end else begin
                    m_cnt <= m_cnt + 1;
                end
            end
        end else if (s_tvalid[m_owner] && s_tlast[m_owner]) begin
            m_rr    <= (m_owner + 1) % NS;
            m_owner <= -1;
            m_drop  <= 1'b0;
        end
    end

    typedef struct {
        int src;
        int pkt;
        int sq;
        bit last;
        int cyc;
    } beat_t;

    beat_t log_q[$];
    int    n_cmp;
    int    n_fail;
    int    cyc;
    bit    tog;

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outputs();
        int          o;
        logic        e_valid;
        logic        e_last;
        logic [63:0] e_data;
        logic [7:0]  e_be;
        logic [1:0]  e_user;
        logic [3:0]  e_ready;
        o       = m_owner;
        e_valid = 1'b0;
        e_last  = 1'b0;
        e_data  = '0;
        e_be    = '0;
        e_user  = '0;
        e_ready = '0;
        if (o >= 0 && !m_drop) begin
            e_valid = s_tvalid[o];
            e_data  = s_tdata[o];
            e_be    = s_be[o];
            e_last  = s_tlast[o] || (m_cnt == MAXB - 1);
            e_user  = 2'(o);
            e_ready = master_tready ? 4'(1 << o) : 4'b0;
        end else if (o >= 0) begin
            e_ready = 4'(1 << o);
        end
        cmp("tvalid", 64'(master_tvalid), 64'(e_valid));
        cmp("tlast", 64'(master_tlast), 64'(e_last));
        cmp("tdata", master_tdata, e_data);
        cmp("byteEnable", 64'(master_be), 64'(e_be));
        cmp("tuser", 64'(master_tuser), 64'(e_user));
        cmp("s_tready", 64'(s_tready), 64'(e_ready));
        cmp("trunc_count", 64'(trunc_count), 64'(m_trunc));
    endtask

    // One clock: check and sample at the falling edge, advance sources just after the rising edge.
    task automatic tick();
        logic [NS-1:0] hs;
        beat_t         b;
        @(negedge clk);
        check_outputs();
        hs = s_tvalid & s_tready;
        if (master_tvalid && master_tready) begin
            b.src  = int'(master_tdata[63:56]);
            b.pkt  = int'(master_tdata[55:32]);
            b.sq   = int'(master_tdata[31:0]);
            b.last = master_tlast;
            b.cyc  = cyc;
            log_q.push_back(b);
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < NS; i++) begin
            if (hs[i]) begin
                if (seq[i] == plen[i] - 1) begin
                    seq[i] = 0;
                    npkt[i]--;
                    pktno[i]++;
                end else begin
                    seq[i]++;
                end
            end
        end
        if (tog) master_tready = ~master_tready;
    endtask

    task automatic do_reset();
        rst           = 1'b0;
        master_tready = 1'b1;
        tog           = 1'b0;
        src_enable    = 4'hF;
        for (int i = 0; i < NS; i++) begin
            npkt[i]  = 0;
            plen[i]  = 1;
            seq[i]   = 0;
            pktno[i] = 0;
        end
        tick();
        tick();
        rst = 1'b1;
        tick();
        log_q.delete();
    endtask

    function automatic bit busy(input logic [NS-1:0] mask);
        for (int i = 0; i < NS; i++) begin
            if (mask[i] && npkt[i] > 0) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic wait_done(input logic [NS-1:0] mask, input int budget, input string name);
        int n;
        n = 0;
        while (busy(mask) && n < budget) begin
            tick();
            n++;
        end
        cmp(name, 64'(busy(mask)), 64'd0);
        tick();
    endtask

    task automatic wait_log(input int cnt, input int budget, input string name);
        int n;
        n = 0;
        while (log_q.size() < cnt && n < budget) begin
            tick();
            n++;
        end
        cmp(name, 64'(log_q.size() >= cnt), 64'd1);
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        cyc    = 0;
        rst    = 1'b0;
        master_tready = 1'b1;
        src_enable    = 4'hF;
        tog    = 1'b0;
        for (int i = 0; i < NS; i++) begin
            npkt[i]  = 0;
            plen[i]  = 1;
            seq[i]   = 0;
            pktno[i] = 0;
        end

        // Two 3-beat packets: src0 then src2 with one idle cycle between.
        do_reset();
        cmp("t1_reset_trunc", 64'(trunc_count), 64'd0);
        npkt[0] = 1; plen[0] = 3;
        npkt[2] = 1; plen[2] = 3;
        wait_done(4'b0101, 50, "t1_timeout");
        cmp("t1_beats", 64'(log_q.size()), 64'd6);
        if (log_q.size() == 6) begin
            cmp("t1_first_src", 64'(log_q[0].src), 64'd0);
            cmp("t1_first_last", 64'(log_q[2].last), 64'd1);
            cmp("t1_second_src", 64'(log_q[3].src), 64'd2);
            cmp("t1_back_to_back", 64'(log_q[1].cyc - log_q[0].cyc), 64'd1);
            cmp("t1_idle_gap", 64'(log_q[3].cyc - log_q[2].cyc), 64'd2);
            cmp("t1_second_last", 64'(log_q[5].last), 64'd1);
        end

        // Everyone sends single-beat packets: strict rotation, one packet every two cycles.
        do_reset();
        for (int i = 0; i < NS; i++) begin
            npkt[i] = 2;
            plen[i] = 1;
        end
        wait_done(4'hF, 100, "t2_timeout");
        cmp("t2_beats", 64'(log_q.size()), 64'd8);
        if (log_q.size() == 8) begin
            for (int k = 0; k < 8; k++) begin
                cmp($sformatf("t2_order_%0d", k), 64'(log_q[k].src), 64'(k % 4));
                cmp($sformatf("t2_last_%0d", k), 64'(log_q[k].last), 64'd1);
            end
            cmp("t2_rate", 64'(log_q[7].cyc - log_q[0].cyc), 64'd14);
        end

        // Backpressure toggling during a 4-beat src1 packet.
        do_reset();
        npkt[1] = 1; plen[1] = 4;
        tog = 1'b1;
        wait_done(4'b0010, 50, "t3_timeout");
        tog = 1'b0;
        master_tready = 1'b1;
        cmp("t3_beats", 64'(log_q.size()), 64'd4);
        if (log_q.size() == 4) begin
            for (int k = 0; k < 4; k++) begin
                cmp($sformatf("t3_seq_%0d", k), 64'(log_q[k].sq), 64'(k));
                cmp($sformatf("t3_src_%0d", k), 64'(log_q[k].src), 64'd1);
            end
            cmp("t3_last", 64'(log_q[3].last), 64'd1);
        end

        // 260-beat packet is cut at 256; an exact 256-beat packet is not.
        do_reset();
        npkt[3] = 1; plen[3] = 260;
        wait_done(4'b1000, 400, "t4_timeout");
        cmp("t4_beats", 64'(log_q.size()), 64'd256);
        if (log_q.size() == 256) begin
            cmp("t4_forced_last", 64'(log_q[255].last), 64'd1);
            cmp("t4_not_early", 64'(log_q[254].last), 64'd0);
            cmp("t4_last_seq", 64'(log_q[255].sq), 64'd255);
        end
        cmp("t4_trunc", 64'(trunc_count), 64'd1);
        npkt[2] = 1; plen[2] = 256;
        wait_done(4'b0100, 400, "t4b_timeout");
        cmp("t4b_beats", 64'(log_q.size()), 64'd512);
        if (log_q.size() == 512) begin
            cmp("t4b_last", 64'(log_q[511].last), 64'd1);
            cmp("t4b_src", 64'(log_q[511].src), 64'd2);
        end
        cmp("t4b_trunc", 64'(trunc_count), 64'd1);

        // Masked src1 is never granted; disabling src0 mid-packet lets it finish.
        do_reset();
        src_enable = 4'b1101;
        npkt[1] = 2; plen[1] = 2;
        npkt[0] = 1; plen[0] = 4;
        wait_log(1, 20, "t5_start_timeout");
        src_enable = 4'b1100;
        wait_done(4'b0001, 50, "t5_timeout");
        repeat (10) tick();
        cmp("t5_beats", 64'(log_q.size()), 64'd4);
        if (log_q.size() == 4) begin
            for (int k = 0; k < 4; k++) begin
                cmp($sformatf("t5_src_%0d", k), 64'(log_q[k].src), 64'd0);
            end
        end
        cmp("t5_src1_pending", 64'(npkt[1]), 64'd2);

        // Reset in the middle of a src2 packet; its tail comes back as a new packet.
        do_reset();
        npkt[2] = 1; plen[2] = 6;
        wait_log(2, 20, "t6_start_timeout");
        cmp("t6_pre_valid", 64'(master_tvalid), 64'd1);
        #2;
        rst = 1'b0;
        #1;
        cmp("t6_rst_valid", 64'(master_tvalid), 64'd0);
        cmp("t6_rst_last", 64'(master_tlast), 64'd0);
        cmp("t6_rst_data", master_tdata, 64'd0);
        cmp("t6_rst_user", 64'(master_tuser), 64'd0);
        cmp("t6_rst_ready", 64'(s_tready), 64'd0);
        cmp("t6_rst_trunc", 64'(trunc_count), 64'd0);
        tick();
        tick();
        rst = 1'b1;
        wait_done(4'b0100, 30, "t6_timeout");
        cmp("t6_beats", 64'(log_q.size()), 64'd6);
        if (log_q.size() == 6) begin
            cmp("t6_resume_seq", 64'(log_q[2].sq), 64'd2);
            cmp("t6_resume_src", 64'(log_q[2].src), 64'd2);
            cmp("t6_last", 64'(log_q[5].last), 64'd1);
        end
        cmp("t6_trunc", 64'(trunc_count), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
